// File: rtl/cb_transform.sv
// cb_transform: nonlinear Cb chroma transform for the skin-tone datapath.
//   C'b = (Cb - Cb_center(Y)) * W_Cb / widthcb(Y) + Cb_center(K_h)
// Luma inside [K_L, K_H] passes Cb through unchanged. Outside that range the
// transform uses one multiply cycle, a 30-cycle restoring divider and one
// finishing cycle. Valid/ready handshakes are used on both sides.
// Build option: define CBT_ROUND_EN to round half up before the final shift.
// Without it the final shift floors. Latency is the same in both builds.
module cb_transform #(
  parameter int unsigned W_W         = 16,
  parameter int unsigned W_FRAC      = 8,
  parameter int unsigned K_L         = 125,
  parameter int unsigned K_H         = 188,
  parameter int unsigned W_CB_FIX    = 12024,
  parameter int unsigned CB_OFFS_FIX = 27648
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     y,
  input  logic [7:0]     cb,
  input  logic [W_W-1:0] widthcb,
  input  logic [W_W-1:0] cb_center,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     cb_t,
  output logic           div0
);

  localparam int unsigned P_W = 30;        // product / quotient width
  localparam int unsigned D_W = W_W + 2;   // signed difference width
  localparam int unsigned R_W = P_W + 2;   // signed result width
  localparam int unsigned C_W = 5;         // divider iteration counter width

`ifdef CBT_ROUND_EN
  localparam int unsigned RND = 1 << (W_FRAC - 1);
`else
  localparam int unsigned RND = 0;
`endif

  localparam logic [7:0]     Y_LO     = 8'(K_L);
  localparam logic [7:0]     Y_HI     = 8'(K_H);
  localparam logic [7:0]     CB_MID   = 8'(CB_OFFS_FIX >> W_FRAC);
  localparam logic [C_W-1:0] LAST_BIT = C_W'(P_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cb_q, cb_d;
  logic [W_W-1:0] wid_q, wid_d;
  logic [W_W-1:0] cen_q, cen_d;
  logic [W_W-1:0] rem_q, rem_d;
  logic [P_W-1:0] pq_q, pq_d;    // dividend in, quotient out (shifted in place)
  logic           neg_q, neg_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [7:0]     cbt_q, cbt_d;
  logic           div0_q, div0_d;

  // Multiply stage: signed difference, its magnitude and the scaled product
  logic [D_W-1:0] diff;
  logic [D_W-1:0] mag;
  logic           diff_neg;
  logic           diff_zero;
  logic [P_W-1:0] prod;

  // Compute the centred chroma difference and |d| * W_Cb
  always_comb begin
    diff      = (D_W'(cb_q) << W_FRAC) - D_W'(cen_q);
    diff_neg  = diff[D_W-1];
    diff_zero = (diff == '0);
    mag       = diff_neg ? -diff : diff;
    prod      = P_W'(mag) * P_W'(W_CB_FIX);
  end

  // Divider step: trial subtraction, the borrow decides the quotient bit
  logic [W_W:0]   trial;
  logic [W_W:0]   trial_sub;
  logic           q_bit;
  logic [W_W-1:0] rem_nxt;

  // One restoring-division iteration on the partial remainder
  always_comb begin
    trial     = {rem_q, pq_q[P_W-1]};
    trial_sub = trial - {1'b0, wid_q};
    q_bit     = ~trial_sub[W_W];
    rem_nxt   = q_bit ? trial_sub[W_W-1:0] : trial[W_W-1:0];
  end

  // Finish stage: apply sign, add offset, optional rounding, shift, clamp
  logic signed [R_W-1:0] q_s;
  logic signed [R_W-1:0] r_s;
  logic signed [R_W-1:0] sh_s;
  logic [7:0]            clamp;

  // Convert the truncated quotient magnitude into the clamped 8-bit result
  always_comb begin
    q_s  = signed'(R_W'(pq_q));
    r_s  = (neg_q ? -q_s : q_s) + signed'(R_W'(CB_OFFS_FIX)) + signed'(R_W'(RND));
    sh_s = r_s >>> W_FRAC;
    if (sh_s < 0) begin
      clamp = '0;
    end else if (sh_s > 255) begin
      clamp = '1;
    end else begin
      clamp = sh_s[7:0];
    end
  end

  // Next-state and datapath register updates per state
  always_comb begin
    state_d = state_q;
    cb_d    = cb_q;
    wid_d   = wid_q;
    cen_d   = cen_q;
    rem_d   = rem_q;
    pq_d    = pq_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    cbt_d   = cbt_q;
    div0_d  = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cb_d  = cb;
          wid_d = widthcb;
          cen_d = cb_center;
          if ((y >= Y_LO) && (y <= Y_HI)) begin
            cbt_d   = cb;
            div0_d  = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        neg_d = diff_neg;
        pq_d  = prod;
        rem_d = '0;
        cnt_d = '0;
        if (wid_q == '0) begin
          div0_d = 1'b1;
          if (diff_zero) begin
            cbt_d = CB_MID;
          end else if (diff_neg) begin
            cbt_d = '0;
          end else begin
            cbt_d = '1;
          end
          state_d = S_OUT;
        end else begin
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        rem_d = rem_nxt;
        pq_d  = {pq_q[P_W-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        cbt_d   = clamp;
        div0_d  = 1'b0;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any work in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cb_q    <= '0;
      wid_q   <= '0;
      cen_q   <= '0;
      rem_q   <= '0;
      pq_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      cbt_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cb_q    <= cb_d;
      wid_q   <= wid_d;
      cen_q   <= cen_d;
      rem_q   <= rem_d;
      pq_q    <= pq_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      cbt_q   <= cbt_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign cb_t      = cbt_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_cb_transform.sv
// Scoreboard bench for cb_transform: the driver queues hand-computed
// results, a monitor pops and checks them whenever out_valid is presented.
module tb_cb_transform;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  y;
  logic [7:0]  cb;
  logic [15:0] widthcb;
  logic [15:0] cb_center;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  cb_t;
  logic        div0;

  always #5 clk = ~clk;

  cb_transform #(
    .W_W        (16),
    .W_FRAC     (8),
    .K_L        (125),
    .K_H        (188),
    .W_CB_FIX   (12024),
    .CB_OFFS_FIX(27648)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .cb       (cb),
    .widthcb  (widthcb),
    .cb_center(cb_center),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cb_t     (cb_t),
    .div0     (div0)
  );

  typedef struct {
    logic [7:0] cbt;
    logic       d0;
    int         first;
    string      name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;

`ifdef CBT_ROUND_EN
  localparam logic [7:0] NEG_MID_EXP = 8'd79;
`else
  localparam logic [7:0] NEG_MID_EXP = 8'd78;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each falling edge
  initial begin
    bit prev_v = 1'b0;
    int first  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) first = cyc;
          check("valid_ready_excl", int'(in_ready), 0);
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got cb_t=%0d div0=%0d, required no output", cb_t, div0);
          end else begin
            check({sb[0].name, ".cb_t"}, int'(cb_t), int'(sb[0].cbt));
            check({sb[0].name, ".div0"}, int'(div0), int'(sb[0].d0));
            if (out_ready) begin
              check({sb[0].name, ".latency"}, first, sb[0].first);
              void'(sb.pop_front());
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic send(input logic [7:0] yy, input logic [7:0] cc,
                      input logic [15:0] ww, input logic [15:0] ce,
                      input logic [7:0] ecb, input logic ed, input int lat,
                      input string nm, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.accept_timeout: got in_ready=0, required 1", nm);
      return;
    end
    y         = yy;
    cb        = cc;
    widthcb   = ww;
    cb_center = ce;
    in_valid  = 1'b1;
    if (push) begin
      e.cbt   = ecb;
      e.d0    = ed;
      e.first = cyc + lat;
      e.name  = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    y         = 8'($urandom);
    cb        = 8'($urandom);
    widthcb   = 16'($urandom);
    cb_center = 16'($urandom);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({nm, ".drained"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y         = '0;
    cb        = '0;
    widthcb   = '0;
    cb_center = '0;
    repeat (3) @(negedge clk);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.in_ready",  int'(in_ready),  1);
    check("reset.cb_t",      int'(cb_t),      0);
    check("reset.div0",      int'(div0),      0);
    rst_n = 1'b1;

    // Pass-through, including both knees
    send(8'd150, 8'd120, 16'd5888, 16'd30208, 8'd120, 1'b0, 1, "pass_150", 1'b1);
    send(8'd125, 8'd77,  16'd5888, 16'd30208, 8'd77,  1'b0, 1, "pass_kl",  1'b1);
    send(8'd188, 8'd200, 16'd5888, 16'd30208, 8'd200, 1'b0, 1, "pass_kh",  1'b1);

    // Full transform
    send(8'd16,  8'd128, 16'd5888, 16'd30208, 8'd128, 1'b0, 33, "xf_128",   1'b1);
    send(8'd16,  8'd118, 16'd5888, 16'd30208, 8'd108, 1'b0, 33, "xf_zero",  1'b1);
    send(8'd124, 8'd118, 16'd5888, 16'd30208, 8'd108, 1'b0, 33, "xf_y124",  1'b1);
    send(8'd189, 8'd128, 16'd5888, 16'd30208, 8'd128, 1'b0, 33, "xf_y189",  1'b1);
    send(8'd240, 8'd110, 16'd4096, 16'd25600, 8'd137, 1'b0, 33, "xf_pos",   1'b1);
    send(8'd100, 8'd100, 16'd4096, 16'd28160, NEG_MID_EXP, 1'b0, 33, "xf_neg", 1'b1);

    // Clamping
    send(8'd16,  8'd255, 16'd5888, 16'd30208, 8'd255, 1'b0, 33, "clamp_hi", 1'b1);
    send(8'd235, 8'd0,   16'd3584, 16'd30208, 8'd0,   1'b0, 33, "clamp_lo", 1'b1);

    // Divide by zero
    send(8'd16, 8'd128, 16'd0, 16'd30208, 8'd255, 1'b1, 2, "div0_pos",  1'b1);
    send(8'd16, 8'd118, 16'd0, 16'd30208, 8'd108, 1'b1, 2, "div0_zero", 1'b1);
    send(8'd16, 8'd0,   16'd0, 16'd30208, 8'd0,   1'b1, 2, "div0_neg",  1'b1);
    drain("vectors");

    // Backpressure: hold a div0 result for 10 cycles
    out_ready = 1'b0;
    send(8'd16, 8'd128, 16'd0, 16'd30208, 8'd255, 1'b1, 2, "bp", 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp.out_valid_seen", int'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      check("bp.in_ready_held", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.in_ready_after", int'(in_ready),  1);
    check("bp.out_valid_after", int'(out_valid), 0);
    drain("bp");

    // Asynchronous reset during the divide
    send(8'd150, 8'd99, 16'd0, 16'd0, 8'd99, 1'b0, 1, "pre_rst", 1'b1);
    drain("pre_rst");
    send(8'd16, 8'd128, 16'd5888, 16'd30208, 8'd0, 1'b0, 0, "aborted", 1'b0);
    repeat (9) @(negedge clk);
    check("rst.busy_in_ready", int'(in_ready), 0);
    check("rst.cb_t_before",   int'(cb_t),     99);
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.cb_t",      int'(cb_t),      0);
    check("rst.div0",      int'(div0),      0);
    check("rst.in_ready",  int'(in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd170, 8'd55, 16'd5888, 16'd30208, 8'd55, 1'b0, 1, "post_rst", 1'b1);
    drain("post_rst");

    repeat (40) @(negedge clk);
    check("final.queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
